// File: rtl/pkt_serializer_if.sv
// Packet request inputs and serial-stream outputs of the packet serializer.
// The bench or upstream logic uses master; the serializer uses slave.
interface pkt_serializer_if;
  logic        go;
  logic [1:0]  pkt_type;
  logic [3:0]  pid;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [63:0] data;
  logic        pause;
  logic        outb;
  logic        start;
  logic        sending;
  logic        eop;
  logic        ready;

  modport master (
    output go, pkt_type, pid, addr, endp, data, pause,
    input  outb, start, sending, eop, ready
  );

  modport slave (
    input  go, pkt_type, pid, addr, endp, data, pause,
    output outb, start, sending, eop, ready
  );
endinterface

// File: rtl/pkt_serializer.sv
// Serializes token/data/handshake packets as SYNC, PID, payload, CRC, EOP, one bit per cycle.
// The first SYNC bit follows go-accept by one cycle; pause freezes bit, state and CRC until released.
module pkt_serializer (
  input  logic            clk,
  input  logic            rst_L,
  pkt_serializer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    PID     = 3'd2,
    PAYLOAD = 3'd3,
    CRC     = 3'd4,
    EOP     = 3'd5
  } state_t;

  localparam logic [1:0]  TYPE_DATA = 2'd1;
  localparam logic [1:0]  TYPE_HS   = 2'd2;
  localparam logic [1:0]  TYPE_RSVD = 2'd3;
  localparam logic [4:0]  POLY5     = 5'b00101;
  localparam logic [15:0] POLY16    = 16'h8005;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [1:0]  type_q, type_d;
  logic [3:0]  pid_q, pid_d;
  logic [63:0] pay_q, pay_d;
  logic [4:0]  crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d;

  logic        is_data;
  logic [6:0]  pay_last;
  logic [6:0]  crc_last;
  logic        pay_bit;
  logic        fb5, fb16;
  logic [2:0]  crc5_idx;
  logic [3:0]  crc16_idx;

  assign is_data   = (type_q == TYPE_DATA);
  assign pay_last  = is_data ? 7'd63 : 7'd10;
  assign crc_last  = is_data ? 7'd15 : 7'd4;
  assign pay_bit   = pay_q[cnt_q[5:0]];
  assign fb5       = pay_bit ^ crc5_q[4];
  assign fb16      = pay_bit ^ crc16_q[15];
  assign crc5_idx  = 3'd4 - cnt_q[2:0];
  assign crc16_idx = 4'd15 - cnt_q[3:0];

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      type_q  <= '0;
      pid_q   <= '0;
      pay_q   <= '0;
      crc5_q  <= '0;
      crc16_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      pid_q   <= pid_d;
      pay_q   <= pay_d;
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    pid_d   = pid_q;
    pay_d   = pay_q;
    crc5_d  = crc5_q;
    crc16_d = crc16_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.go && bus.pkt_type != TYPE_RSVD) begin
          type_d  = bus.pkt_type;
          pid_d   = bus.pid;
          // Token payload is packed so addr then endp fall out of the same LSB-first index.
          pay_d   = (bus.pkt_type == TYPE_DATA) ? bus.data : {53'd0, bus.endp, bus.addr};
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (!bus.pause) begin
          if (cnt_q == 7'd7) begin
            cnt_d   = '0;
            state_d = PID;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      PID: begin
        crc5_d  = '1;
        crc16_d = '1;
        if (!bus.pause) begin
          if (cnt_q == 7'd7) begin
            cnt_d   = '0;
            state_d = (type_q == TYPE_HS) ? EOP : PAYLOAD;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      PAYLOAD: begin
        if (!bus.pause) begin
          crc5_d  = {crc5_q[3:0], 1'b0} ^ (fb5 ? POLY5 : 5'd0);
          crc16_d = {crc16_q[14:0], 1'b0} ^ (fb16 ? POLY16 : 16'd0);
          if (cnt_q == pay_last) begin
            cnt_d   = '0;
            state_d = CRC;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      CRC: begin
        if (!bus.pause) begin
          if (cnt_q == crc_last) begin
            cnt_d   = '0;
            state_d = EOP;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      EOP: begin
        if (cnt_q == 7'd2) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.outb    = 1'b1;
    bus.start   = 1'b0;
    bus.sending = 1'b0;
    bus.eop     = 1'b0;
    bus.ready   = 1'b0;
    case (state_q)
      IDLE: bus.ready = 1'b1;
      SYNC: begin
        bus.outb    = (cnt_q[2:0] == 3'd7);
        bus.start   = 1'b1;
        bus.sending = 1'b1;
      end
      PID: begin
        bus.outb    = cnt_q[2] ? ~pid_q[cnt_q[1:0]] : pid_q[cnt_q[1:0]];
        bus.start   = 1'b1;
        bus.sending = 1'b1;
      end
      PAYLOAD: begin
        bus.outb    = pay_bit;
        bus.sending = 1'b1;
      end
      CRC: begin
        // Residual goes out complemented, MSB first.
        bus.outb    = is_data ? ~crc16_q[crc16_idx] : ~crc5_q[crc5_idx];
        bus.sending = 1'b1;
      end
      EOP: begin
        bus.outb = 1'b0;
        bus.eop  = 1'b1;
      end
      default: bus.ready = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_pkt_serializer.sv
// Randomized bench for pkt_serializer against a bit-list model with long-division CRC.
module tb_pkt_serializer;
  logic clk = 1'b0;
  logic rst_L;
  always #5 clk = ~clk;

  pkt_serializer_if bus();
  pkt_serializer dut (.clk(clk), .rst_L(rst_L), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;
  bit exp_q[$];
  logic [127:0] obs;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [4:0] outs();
    return {bus.outb, bus.start, bus.sending, bus.eop, bus.ready};
  endfunction

  // Expected outb sequence from first SYNC bit through last CRC bit.
  task automatic build_exp(input logic [1:0] ty, input logic [3:0] p, input logic [6:0] a,
                           input logic [3:0] e, input logic [63:0] d);
    bit msg[$];
    bit r[$];
    int n;
    logic [16:0] g;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(i == 7);
    for (int i = 0; i < 4; i++) exp_q.push_back(p[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(~p[i]);
    if (ty == 2'd2) return;
    if (ty == 2'd0) begin
      for (int i = 0; i < 7; i++) msg.push_back(a[i]);
      for (int i = 0; i < 4; i++) msg.push_back(e[i]);
      n = 5;
      g = 17'h00025;
    end else begin
      for (int i = 0; i < 64; i++) msg.push_back(d[i]);
      n = 16;
      g = 17'h18005;
    end
    foreach (msg[i]) exp_q.push_back(msg[i]);
    // All-ones preset == complementing the leading n message bits, then plain division of M*x^n.
    r = msg;
    for (int i = 0; i < n; i++) r[i] = ~r[i];
    for (int i = 0; i < n; i++) r.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (r[i])
        for (int j = 0; j <= n; j++) r[i+j] = r[i+j] ^ g[n-j];
    for (int k = 0; k < n; k++) exp_q.push_back(~r[msg.size()+k]);
  endtask

  // pmode: 0 none, 1 random single-cycle pauses, 2 one pause every 7 payload bits.
  task automatic run_pkt(input logic [1:0] ty, input logic [3:0] p, input logic [6:0] a,
                         input logic [3:0] e, input logic [63:0] d, input int pmode,
                         input bit noise, input int rst_at, output logic [127:0] ob);
    int idx = 0;
    int cyc = 0;
    int npause = 0;
    bit held = 0;
    bit pz;
    ob = '0;
    build_exp(ty, p, a, e, d);
    bus.pkt_type = ty; bus.pid = p; bus.addr = a; bus.endp = e; bus.data = d;
    bus.go = 1'b1;
    bus.pause = 1'($urandom_range(1));
    @(posedge clk); #1;
    bus.go = 1'b0;
    bus.pause = 1'b0;
    while (idx < exp_q.size() && cyc < 1000) begin
      if (idx == rst_at) begin
        rst_L = 1'b0;
        #1;
        check("rst_mid", 64'(outs()), 64'(5'b10001));
        bus.pause = 1'b0;
        @(negedge clk);
        rst_L = 1'b1;
        return;
      end
      check($sformatf("bit%0d", idx), 64'(outs()), 64'({exp_q[idx], idx < 16, 3'b100}));
      pz = 1'b0;
      if (pmode == 1) pz = !held && ($urandom_range(3) == 0);
      if (pmode == 2) pz = !held && idx >= 16 && idx < 80 && ((idx - 16) % 7 == 6);
      if (noise) begin
        bus.go = 1'($urandom_range(1));
        bus.pkt_type = 2'($urandom_range(3));
        bus.pid = 4'($urandom); bus.addr = 7'($urandom); bus.endp = 4'($urandom);
        bus.data = {$urandom, $urandom};
      end
      bus.pause = pz;
      if (!pz) begin
        ob = {ob[126:0], bus.outb};
        idx++;
      end else begin
        npause++;
      end
      held = pz;
      @(posedge clk); #1;
      cyc++;
    end
    bus.go = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.pause = 1'($urandom_range(1));
      check("eop", 64'(outs()), 64'(5'b00010));
      @(posedge clk); #1;
      cyc++;
    end
    bus.pause = 1'b0;
    check("idle_after", 64'(outs()), 64'(5'b10001));
    check("pkt_len", 64'(cyc), 64'(exp_q.size() + 3 + npause));
  endtask

  initial begin
    rst_L = 1'b0;
    bus.go = 1'b0; bus.pkt_type = 2'd0; bus.pid = 4'd0; bus.addr = 7'd0;
    bus.endp = 4'd0; bus.data = 64'd0; bus.pause = 1'b0;
    #1;
    check("reset_state", 64'(outs()), 64'(5'b10001));
    repeat (3) @(posedge clk);
    @(negedge clk) rst_L = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", 64'(outs()), 64'(5'b10001));

    run_pkt(2'd0, 4'b0001, 7'h15, 4'hE, 64'd0, 0, 1'b0, -1, obs);
    check("tok_vec", 64'(obs[31:0]),
          64'({8'b00000001, 8'b10000111, 11'b10101000111, 5'b10111}));

    run_pkt(2'd2, 4'b0010, 7'h00, 4'h0, 64'd0, 0, 1'b0, -1, obs);
    check("hs_vec", 64'(obs[15:0]), 64'({8'b00000001, 8'b01001011}));

    run_pkt(2'd1, 4'b0011, 7'h00, 4'h0, 64'h0706050403020100, 2, 1'b0, -1, obs);
    check("data_byte1", 64'(obs[71:64]), 64'(8'b10000000));

    run_pkt(2'd1, 4'b1100, 7'h00, 4'h0, {$urandom, $urandom}, 0, 1'b1, -1, obs);
    @(posedge clk); #1;
    check("no_restart", 64'(outs()), 64'(5'b10001));

    run_pkt(2'd0, 4'hA, 7'h33, 4'h5, 64'd0, 0, 1'b0, 29, obs);
    @(posedge clk); #1;
    check("idle_after_rst", 64'(outs()), 64'(5'b10001));
    run_pkt(2'd0, 4'h9, 7'h7F, 4'h3, 64'd0, 0, 1'b0, -1, obs);

    bus.go = 1'b1;
    bus.pkt_type = 2'd3;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("rsvd_idle", 64'(outs()), 64'(5'b10001));
    end
    bus.go = 1'b0;

    for (int t = 0; t < 6; t++) begin
      run_pkt(2'($urandom_range(2)), 4'($urandom), 7'($urandom), 4'($urandom),
              {$urandom, $urandom}, 1, 1'b0, -1, obs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
